// File: rtl/obstacle_scroller.sv
// Three-lane obstacle window that scrolls toward the runner, requests new shapes,
// detects collisions and keeps score. Define SPEEDUP_EN to shorten the scroll period as score grows.
module obstacle_scroller #(
  parameter int NUM_COLS = 8,
  parameter int TICK_DIV = 50,
  parameter int SCORE_W  = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    enable,
  input  logic [1:0]              top_shape,
  input  logic [1:0]              mid_shape,
  input  logic [1:0]              bottom_shape,
  input  logic [1:0]              player_lane,
  output logic                    update,
  output logic [2*NUM_COLS-1:0]   lane_top,
  output logic [2*NUM_COLS-1:0]   lane_mid,
  output logic [2*NUM_COLS-1:0]   lane_bot,
  output logic [SCORE_W-1:0]      score,
  output logic                    game_over
);

  // state | meaning
  // IDLE  | waiting for start; tick held at 0, lanes held
  // RUN   | scrolling (paused while enable=0), collision check active
  // HIT   | runner collided; everything frozen until start
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;

  localparam int TW = $clog2(TICK_DIV + 1);

  logic [1:0]         state;
  logic [TW-1:0]      tick;
  logic [TW-1:0]      period;
  logic [1:0]         sel_col0;
  logic               hit;
  logic               departing;
  logic               tick_last;
  logic               scroll_en;
  logic               restart;
  logic [SCORE_W-1:0] score_next;

  always_comb begin
    sel_col0 = 2'b00;
    case (player_lane)
      2'd0:    sel_col0 = lane_top[1:0];
      2'd1:    sel_col0 = lane_mid[1:0];
      2'd2:    sel_col0 = lane_bot[1:0];
      default: sel_col0 = 2'b00;
    endcase
  end

  assign hit        = (player_lane != 2'd3) && (sel_col0 != 2'b00);
  assign departing  = (|lane_top[1:0]) | (|lane_mid[1:0]) | (|lane_bot[1:0]);
  assign score_next = (departing && (score != {SCORE_W{1'b1}})) ? score + 1'b1 : score;
  assign tick_last  = (tick == period - TW'(1));
  assign scroll_en  = (state == RUN) && !hit && enable && tick_last;
  assign restart    = start && ((state == IDLE) || (state == HIT));
  assign game_over  = (state == HIT);

`ifdef SPEEDUP_EN
  localparam int MIN_PERIOD = TICK_DIV >> 2;

  function automatic logic [TW-1:0] speed_period(input logic [SCORE_W-1:0] s);
    logic [31:0] dec;
    dec = 32'(s >> 4) * 32'(TICK_DIV >> 3);
    if (dec >= 32'(TICK_DIV - MIN_PERIOD))
      return TW'(MIN_PERIOD);
    else
      return TW'(32'(TICK_DIV) - dec);
  endfunction

  // Period follows the score committed by the same scroll.
  always_ff @(posedge clk) begin
    if (reset)
      period <= TW'(TICK_DIV);
    else if (restart)
      period <= TW'(TICK_DIV);
    else if (scroll_en)
      period <= speed_period(score_next);
  end
`else
  assign period = TW'(TICK_DIV);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= '0;
      lane_top <= '0;
      lane_mid <= '0;
      lane_bot <= '0;
      score    <= '0;
      update   <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          tick <= '0;
          if (start) begin
            lane_top <= '0;
            lane_mid <= '0;
            lane_bot <= '0;
            score    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Collision wins over a scroll falling on the same cycle.
          if (hit) begin
            state <= HIT;
          end else if (enable) begin
            if (tick_last) begin
              tick     <= '0;
              lane_top <= {top_shape,    lane_top[2*NUM_COLS-1:2]};
              lane_mid <= {mid_shape,    lane_mid[2*NUM_COLS-1:2]};
              lane_bot <= {bottom_shape, lane_bot[2*NUM_COLS-1:2]};
              score    <= score_next;
              update   <= 1'b1;
            end else begin
              tick <= tick + TW'(1);
            end
          end
        end
        HIT: begin
          if (start) begin
            lane_top <= '0;
            lane_mid <= '0;
            lane_bot <= '0;
            score    <= '0;
            tick     <= '0;
            state    <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
